sync_fifo_flags: RTL



---
 rtl/sync_fifo_flags_pkg.sv | 27 ++
 rtl/sync_fifo_flags_if.sv | 31 +++
 rtl/sync_fifo_flags_ram.sv | 28 ++
 rtl/sync_fifo_flags.sv | 113 +++++++++++
 4 files changed

// File: rtl/sync_fifo_flags_pkg.sv
// Shared parameters and elaboration helpers for the flagged synchronous FIFO.
package sync_fifo_flags_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 6;
    localparam int unsigned DEF_FWFT       = 0;
    localparam int unsigned DEF_AF_THRESH  = 60;
    localparam int unsigned DEF_AE_THRESH  = 4;

    // Number of words addressed by an ADDR_WIDTH-bit index.
    function automatic int unsigned depth_of(input int unsigned addr_width);
        return 32'(1) << addr_width;
    endfunction

    // Address bits needed to hold a given depth (inverse of depth_of).
    function automatic int unsigned addr_bits_for(input int unsigned depth);
        return 32'($clog2(depth));
    endfunction

    // Thresholds must leave both flags reachable: AF in 1..DEPTH, AE in 0..DEPTH-1.
    function automatic bit thresh_legal(input int unsigned af,
                                        input int unsigned ae,
                                        input int unsigned depth);
        return (af >= 32'd1) && (af <= depth) && (ae < depth);
    endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer handshake and status bundle for sync_fifo_flags.
interface sync_fifo_flags_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6
);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  flush;
    logic                  clr_err;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, data_in, rd_en, flush, clr_err,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en, flush, clr_err,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_flags_ram.sv
// Flop-array storage: one synchronous write port, one asynchronous read port.
module sync_fifo_flags_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read of the addressed word.
    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, almost flags, flush and sticky error flags.
module sync_fifo_flags
    import sync_fifo_flags_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned FWFT       = DEF_FWFT,
    parameter int unsigned AF_THRESH  = DEF_AF_THRESH,
    parameter int unsigned AE_THRESH  = DEF_AE_THRESH
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_flags_if.slave bus
);

    localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
    localparam int unsigned PW    = ADDR_WIDTH + 1;

    // Reject thresholds that would make a flag unreachable or stuck.
    if (!thresh_legal(AF_THRESH, AE_THRESH, DEPTH)) begin : g_bad_thresh
        $error("sync_fifo_flags: AF_THRESH=%0d AE_THRESH=%0d illegal for DEPTH=%0d",
               AF_THRESH, AE_THRESH, DEPTH);
    end

    logic [PW-1:0]         wptr_q, rptr_q, wptr_d, rptr_d;
    logic [PW-1:0]         count_q, count_d;
    logic                  full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
    logic                  ovf_d, unf_d;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] rd_data;

    // Accept/reject decisions, next pointers and next status, all from registered flags.
    always_comb begin
        wr_acc = bus.wr_en & ~full_q  & ~bus.flush;
        rd_acc = bus.rd_en & ~empty_q & ~bus.flush;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (bus.flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + PW'(1);
            if (rd_acc) rptr_d = rptr_q + PW'(1);
        end
        count_d = wptr_d - rptr_d;
        ovf_d   = (ovf_q & ~bus.clr_err) | (bus.wr_en & full_q  & ~bus.flush);
        unf_d   = (unf_q & ~bus.clr_err) | (bus.rd_en & empty_q & ~bus.flush);
    end

    // Pointer, count, flag and error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= (count_d == PW'(DEPTH));
            empty_q <= (count_d == '0);
            af_q    <= (count_d >= PW'(AF_THRESH));
            ae_q    <= (count_d <= PW'(AE_THRESH));
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    sync_fifo_flags_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr_q[ADDR_WIDTH-1:0]),
        .wdata (bus.data_in),
        .raddr (rptr_q[ADDR_WIDTH-1:0]),
        .rdata (rd_data)
    );

    // Read data path: head word shown directly, or captured on each accepted read.
    if (FWFT != 0) begin : g_fwft
        assign bus.data_out = rd_data;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;

        // Registered read port; holds between accepted reads and across flush.
        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= rd_data;
            end
        end

        assign bus.data_out = dout_q;
    end

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule
